// File: rtl/qgate_unit_if.sv
// Sample-in / sample-out handshake bundle for qgate_unit: valid/ready on both sides,
// four signed amplitude components each way, plus the saturation flag.
interface qgate_unit_if #(
  parameter int WIDTH = 8
);
  logic                    in_valid;
  logic                    in_ready;
  logic [1:0]              in_mode;
  logic signed [WIDTH-1:0] alpha_r;
  logic signed [WIDTH-1:0] alpha_i;
  logic signed [WIDTH-1:0] beta_r;
  logic signed [WIDTH-1:0] beta_i;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [WIDTH-1:0] new_alpha_r;
  logic signed [WIDTH-1:0] new_alpha_i;
  logic signed [WIDTH-1:0] new_beta_r;
  logic signed [WIDTH-1:0] new_beta_i;
  logic                    out_sat;

  modport master (
    output in_valid, in_mode, alpha_r, alpha_i, beta_r, beta_i, out_ready,
    input  in_ready, out_valid, new_alpha_r, new_alpha_i, new_beta_r, new_beta_i, out_sat
  );

  modport slave (
    input  in_valid, in_mode, alpha_r, alpha_i, beta_r, beta_i, out_ready,
    output in_ready, out_valid, new_alpha_r, new_alpha_i, new_beta_r, new_beta_i, out_sat
  );
endinterface

// File: rtl/qgate_unit.sv
// Single-qubit gate (H/X/Z/S) on a fixed-point amplitude pair, 3-stage elastic pipeline.
// Define QGATE_SAT_EN to saturate results and report clipping on out_sat; otherwise results wrap.
module qgate_unit #(
  parameter int WIDTH = 8,
  parameter int FRAC  = 4
) (
  input  logic        clk,
  input  logic        rst,
  qgate_unit_if.slave io
);
  typedef enum logic [1:0] {GATE_H = 2'd0, GATE_X = 2'd1, GATE_Z = 2'd2, GATE_S = 2'd3} gate_e;

  localparam int SW = WIDTH + 1;
  localparam int PW = WIDTH + FRAC + 3;

  // round(2^frac / sqrt(2)) without reals: largest c with (2c-1)^2 <= 2^(2*frac+1)
  function automatic int inv_sqrt2_const(input int frac);
    int c;
    c = 0;
    for (int i = 1; i <= (1 << frac); i++) begin
      if ((2 * i - 1) * (2 * i - 1) <= (1 << (2 * frac + 1))) c = i;
    end
    return c;
  endfunction

  localparam int C = inv_sqrt2_const(FRAC);
  localparam logic signed [PW-1:0] C_MUL   = PW'(C);
  localparam logic signed [PW-1:0] RND     = PW'(1 << (FRAC - 1));
  localparam logic signed [PW-1:0] LIM_MAX = PW'((1 << (WIDTH - 1)) - 1);
  localparam logic signed [PW-1:0] LIM_MIN = PW'(-(1 << (WIDTH - 1)));

  logic s1_vld_q, s1_vld_d, s2_vld_q, s2_vld_d, out_vld_q, out_vld_d;
  gate_e s1_mode_q, s1_mode_d, s2_mode_q, s2_mode_d;
  logic signed [SW-1:0]    s1_val_q [4];
  logic signed [SW-1:0]    s1_val_d [4];
  logic signed [PW-1:0]    s2_val_q [4];
  logic signed [PW-1:0]    s2_val_d [4];
  logic signed [WIDTH-1:0] res_q [4];
  logic signed [WIDTH-1:0] res_d [4];
  logic signed [SW-1:0]    in_ext [4];
  logic signed [SW-1:0]    route [4];
  logic signed [PW-1:0]    pre [4];
  logic s1_free, s2_free, s3_free, accept;
`ifdef QGATE_SAT_EN
  logic out_sat_q, out_sat_d;
`endif

  // A stage is free when empty or when its contents leave this cycle
  assign s3_free     = !out_vld_q || io.out_ready;
  assign s2_free     = !s2_vld_q || s3_free;
  assign s1_free     = !s1_vld_q || s2_free;
  assign io.in_ready = s1_free && !rst;
  assign accept      = io.in_valid && io.in_ready;

  always_comb begin
    in_ext[0] = SW'(io.alpha_r);
    in_ext[1] = SW'(io.alpha_i);
    in_ext[2] = SW'(io.beta_r);
    in_ext[3] = SW'(io.beta_i);
    route     = in_ext;
    case (gate_e'(io.in_mode))
      GATE_H: begin
        route[0] = in_ext[0] + in_ext[2];
        route[1] = in_ext[1] + in_ext[3];
        route[2] = in_ext[0] - in_ext[2];
        route[3] = in_ext[1] - in_ext[3];
      end
      GATE_X: begin
        route[0] = in_ext[2];
        route[1] = in_ext[3];
        route[2] = in_ext[0];
        route[3] = in_ext[1];
      end
      GATE_Z: begin
        route[2] = -in_ext[2];
        route[3] = -in_ext[3];
      end
      default: begin
        route[2] = -in_ext[3];
        route[3] = in_ext[2];
      end
    endcase
    s1_vld_d  = s1_free ? accept : s1_vld_q;
    s1_mode_d = accept ? gate_e'(io.in_mode) : s1_mode_q;
    s1_val_d  = accept ? route : s1_val_q;
  end

  always_comb begin
    s2_vld_d  = s2_free ? s1_vld_q : s2_vld_q;
    s2_mode_d = s2_mode_q;
    s2_val_d  = s2_val_q;
    if (s1_vld_q && s2_free) begin
      s2_mode_d = s1_mode_q;
      for (int k = 0; k < 4; k++) begin
        s2_val_d[k] = (s1_mode_q == GATE_H) ? PW'(s1_val_q[k]) * C_MUL : PW'(s1_val_q[k]);
      end
    end
  end

  always_comb begin
    out_vld_d = s3_free ? s2_vld_q : out_vld_q;
    res_d     = res_q;
    for (int k = 0; k < 4; k++) begin
      pre[k] = (s2_mode_q == GATE_H) ? (s2_val_q[k] + RND) >>> FRAC : s2_val_q[k];
    end
`ifdef QGATE_SAT_EN
    out_sat_d = out_sat_q;
`endif
    if (s2_vld_q && s3_free) begin
`ifdef QGATE_SAT_EN
      out_sat_d = 1'b0;
      for (int k = 0; k < 4; k++) begin
        if (pre[k] > LIM_MAX) begin
          res_d[k]  = WIDTH'(LIM_MAX);
          out_sat_d = 1'b1;
        end else if (pre[k] < LIM_MIN) begin
          res_d[k]  = WIDTH'(LIM_MIN);
          out_sat_d = 1'b1;
        end else begin
          res_d[k]  = WIDTH'(pre[k]);
        end
      end
`else
      for (int k = 0; k < 4; k++) res_d[k] = WIDTH'(pre[k]);
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld_q  <= 1'b0;
      s2_vld_q  <= 1'b0;
      out_vld_q <= 1'b0;
      s1_mode_q <= GATE_H;
      s2_mode_q <= GATE_H;
      for (int k = 0; k < 4; k++) begin
        s1_val_q[k] <= '0;
        s2_val_q[k] <= '0;
        res_q[k]    <= '0;
      end
`ifdef QGATE_SAT_EN
      out_sat_q <= 1'b0;
`endif
    end else begin
      s1_vld_q  <= s1_vld_d;
      s2_vld_q  <= s2_vld_d;
      out_vld_q <= out_vld_d;
      s1_mode_q <= s1_mode_d;
      s2_mode_q <= s2_mode_d;
      s1_val_q  <= s1_val_d;
      s2_val_q  <= s2_val_d;
      res_q     <= res_d;
`ifdef QGATE_SAT_EN
      out_sat_q <= out_sat_d;
`endif
    end
  end

  assign io.out_valid   = out_vld_q;
  assign io.new_alpha_r = res_q[0];
  assign io.new_alpha_i = res_q[1];
  assign io.new_beta_r  = res_q[2];
  assign io.new_beta_i  = res_q[3];
`ifdef QGATE_SAT_EN
  assign io.out_sat     = out_sat_q;
`else
  assign io.out_sat     = 1'b0;
`endif
endmodule

// File: tb/tb_qgate_unit.sv
// Directed + random bench for qgate_unit (WIDTH=8, FRAC=4) with a scoreboard queue.
module tb_qgate_unit;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  qgate_unit_if #(.WIDTH(8)) io();
  qgate_unit #(.WIDTH(8), .FRAC(4)) dut (.clk(clk), .rst(rst), .io(io));

  typedef struct {
    int ar;
    int ai;
    int br;
    int bi;
    int sat;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int hmul(input int x);
    return (x * 11 + 8) >>> 4;
  endfunction

  function automatic int lim(input int v);
`ifdef QGATE_SAT_EN
    if (v > 127) return 127;
    if (v < -128) return -128;
    return v;
`else
    return ((v & 255) ^ 128) - 128;
`endif
  endfunction

  function automatic int clip(input int v);
`ifdef QGATE_SAT_EN
    return (v > 127 || v < -128) ? 1 : 0;
`else
    return (v == v + 1) ? 1 : 0;
`endif
  endfunction

  function automatic exp_t model(input int m, input int ar, input int ai, input int br, input int bi);
    int r[4];
    exp_t e;
    case (m)
      0:       r = '{hmul(ar + br), hmul(ai + bi), hmul(ar - br), hmul(ai - bi)};
      1:       r = '{br, bi, ar, ai};
      2:       r = '{ar, ai, -br, -bi};
      default: r = '{ar, ai, -bi, br};
    endcase
    e.ar  = lim(r[0]);
    e.ai  = lim(r[1]);
    e.br  = lim(r[2]);
    e.bi  = lim(r[3]);
    e.sat = (clip(r[0]) | clip(r[1]) | clip(r[2]) | clip(r[3]));
    return e;
  endfunction

  // Output monitor: every completed output handshake is checked against the queue head
  always @(negedge clk) begin
    exp_t e;
    if (!rst && io.out_valid && io.out_ready) begin
      if (sb.size() == 0) begin
        chk("spurious_out_valid", io.out_valid, 1'b0);
      end else begin
        e = sb.pop_front();
        chk("new_alpha_r", io.new_alpha_r, e.ar);
        chk("new_alpha_i", io.new_alpha_i, e.ai);
        chk("new_beta_r", io.new_beta_r, e.br);
        chk("new_beta_i", io.new_beta_i, e.bi);
        chk("out_sat", io.out_sat, e.sat);
      end
    end
  end

  task automatic send(input int m, input int ar, input int ai, input int br, input int bi);
    int waited = 0;
    io.in_valid = 1'b1;
    io.in_mode  = 2'(m);
    io.alpha_r  = 8'(ar);
    io.alpha_i  = 8'(ai);
    io.beta_r   = 8'(br);
    io.beta_i   = 8'(bi);
    @(negedge clk);
    while (!io.in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    chk("in_ready_for_send", io.in_ready, 1'b1);
    if (io.in_ready) sb.push_back(model(m, ar, ai, br, bi));
    @(posedge clk);
    #1;
    io.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_remaining", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    io.in_valid  = 1'b0;
    io.in_mode   = 2'd0;
    io.alpha_r   = '0;
    io.alpha_i   = '0;
    io.beta_r    = '0;
    io.beta_i    = '0;
    io.out_ready = 1'b1;

    #1 rst = 1'b1;
    #1;
    chk("rst_in_ready", io.in_ready, 1'b0);
    chk("rst_out_valid", io.out_valid, 1'b0);
    chk("rst_new_alpha_r", io.new_alpha_r, 0);
    chk("rst_out_sat", io.out_sat, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_rst", io.in_ready, 1'b1);
    @(posedge clk);
    #1;

    // Latency: output appears in the third cycle after acceptance
    send(0, 16, 0, 0, 0);
    @(negedge clk);
    chk("latency_c1_out_valid", io.out_valid, 1'b0);
    @(negedge clk);
    chk("latency_c2_out_valid", io.out_valid, 1'b0);
    @(negedge clk);
    chk("latency_c3_out_valid", io.out_valid, 1'b1);
    @(posedge clk);
    #1;

    // Back-to-back directed boundary samples
    send(0, 127, 0, 127, 0);
    send(1, 16, 0, 0, -16);
    send(3, -7, 9, 5, 3);
    send(2, 3, -4, 5, 3);
    send(2, 1, 2, -128, 0);
    send(0, -20, 7, 3, -9);
    send(0, -128, -128, -128, -128);
    send(3, 0, 0, 4, -128);
    for (int i = 0; i < 16; i++) begin
      send(int'($urandom_range(3)), int'($urandom_range(255)) - 128, int'($urandom_range(255)) - 128,
           int'($urandom_range(255)) - 128, int'($urandom_range(255)) - 128);
    end
    drain();

    // Stall: three samples fill the pipe while out_ready is low
    io.out_ready = 1'b0;
    send(1, 10, 20, 30, 40);
    send(0, 50, -60, 70, -8);
    send(3, 1, 2, 3, 4);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("stall_in_ready", io.in_ready, 1'b0);
      chk("stall_out_valid", io.out_valid, 1'b1);
      chk("stall_new_alpha_r", io.new_alpha_r, sb[0].ar);
      chk("stall_new_beta_i", io.new_beta_i, sb[0].bi);
    end
    @(posedge clk);
    #1 io.out_ready = 1'b1;
    drain();

    // Reset with three samples in flight: all dropped
    io.out_ready = 1'b0;
    send(0, 16, 0, 0, 0);
    send(1, 5, 6, 7, 8);
    send(2, 9, 10, 11, 12);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", io.out_valid, 1'b0);
    chk("midrst_new_alpha_r", io.new_alpha_r, 0);
    chk("midrst_new_beta_i", io.new_beta_i, 0);
    chk("midrst_out_sat", io.out_sat, 1'b0);
    chk("midrst_in_ready", io.in_ready, 1'b0);
    sb.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    io.out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("post_rst_out_valid", io.out_valid, 1'b0);
    end
    chk("post_rst_in_ready", io.in_ready, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/qgate_unit.md
QGATE_UNIT -- requirements
Module: qgate_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 8: signed two's-complement width of every amplitude component.
REQ-002 SHALL have parameter FRAC, default 4: fractional bits of the amplitude format (WIDTH=8, FRAC=4 is S3.4).
REQ-003 SHALL have ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  input sample present.
- in_ready  out  1  unit accepts a sample this cycle.
- in_mode  in  2  gate select: 0=H, 1=X, 2=Z, 3=S.
- alpha_r, alpha_i, beta_r, beta_i  in  WIDTH each  signed input amplitudes.
- out_valid  out  1  output sample present.
- out_ready  in  1  downstream accepts the output sample.
- new_alpha_r, new_alpha_i, new_beta_r, new_beta_i  out  WIDTH each  signed result amplitudes.
- out_sat  out  1  saturation occurred on this output sample (only with QGATE_SAT_EN).

Function
REQ-004 SHALL accept a sample when in_valid && in_ready; in_mode is captured with the sample and travels with it through the pipeline.
REQ-005 SHALL be a 3-stage pipeline: S1 add/subtract/route, S2 constant multiply, S3 round/limit/output register; latency is exactly 3 cycles from acceptance to out_valid when out_ready is held high.
REQ-006 SHALL sustain one sample per cycle with out_ready high.
REQ-007 SHALL hold a stage when it is valid and the next stage is valid and not advancing; a stage SHALL advance into an empty stage regardless of out_ready (bubbles collapse).
REQ-008 SHALL drive in_ready = !S1_valid || S1_advancing, combinationally.
REQ-009 SHALL hold out_valid and all outputs stable while out_valid && !out_ready.
REQ-010 SHALL compute H as new_alpha = (alpha+beta)*C, new_beta = (alpha-beta)*C, per real and imaginary part, with C = round(2^FRAC / sqrt(2)), a localparam (11 at FRAC=4).
REQ-011 SHALL form the S1 sums and differences at WIDTH+1 bits and the S2 products at full precision with no overflow.
REQ-012 SHALL round each H product by adding 2^(FRAC-1), then arithmetic-shifting right by FRAC (round half up).
REQ-013 SHALL compute X as a swap: new_alpha = beta, new_beta = alpha.
REQ-014 SHALL compute Z as new_alpha = alpha, new_beta = -beta.
REQ-015 SHALL compute S as new_alpha = alpha, new_beta = (-beta_i, beta_r).
REQ-016 SHALL route X, Z and S through the same 3 stages, with no multiply or rounding applied.
REQ-017 SHALL reduce every result component to WIDTH bits as set by REQ-025 and REQ-026; negating -2^(WIDTH-1) is an overflow case.

Reset
REQ-018 SHALL, on assertion of rst, immediately clear all stage valid flags, out_valid and out_sat, and force all new_* outputs to 0.
REQ-019 SHALL drop in-flight samples when reset is asserted mid-operation; none SHALL emerge after reset.
REQ-020 SHALL drive in_ready low while rst is asserted.
REQ-021 SHALL drive in_ready high in the first cycle after rst deasserts.

Configuration
REQ-022 SHALL use the macro QGATE_SAT_EN.
REQ-023 With QGATE_SAT_EN defined, the unit SHALL saturate every result component to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
REQ-024 With QGATE_SAT_EN defined, out_sat SHALL be high for an output sample when any of its 4 components clipped.
REQ-025 Without QGATE_SAT_EN, the unit SHALL truncate every result component to its low WIDTH bits (wrap-around).
REQ-026 Without QGATE_SAT_EN, out_sat SHALL be tied to 0.

Verification (WIDTH=8, FRAC=4)
REQ-027 SHALL cover H with alpha=(16,0), beta=(0,0), out_ready=1 -> 3 cycles later new_alpha=(11,0), new_beta=(11,0).
REQ-028 SHALL cover H with alpha=(127,0), beta=(127,0) -> with macro new_alpha_r=127, out_sat=1; without macro new_alpha_r=-81; new_beta_r=0 in both cases.
REQ-029 SHALL cover X with alpha=(16,0), beta=(0,-16) -> new_alpha=(0,-16), new_beta=(16,0); S with beta=(5,3) -> new_beta=(-3,5); Z with beta=(5,3) -> new_beta=(-5,-3).
REQ-030 SHALL cover Z with beta_r=-128 -> with macro new_beta_r=127, out_sat=1; without macro new_beta_r=-128.
REQ-031 SHALL cover back-to-back samples with out_ready low for 5 cycles -> 3 samples held (one per stage), in_ready low, out_valid and outputs stable; order and values preserved when out_ready returns high.
REQ-032 SHALL cover rst pulse while 3 samples are in flight -> out_valid=0 and outputs=0 immediately; no stale sample after release.
